// File: rtl/ula_defs_pkg.sv
// Shared ULA select codes, RV32I opcodes and decode control types for the issue stage.
package ula_defs_pkg;

  localparam int unsigned SEL_W = 4;
  localparam int unsigned OPC_W = 7;

  typedef logic [SEL_W-1:0] ula_sel_t;

  localparam ula_sel_t ULA_NONE  = 4'd0;
  localparam ula_sel_t ULA_ADD   = 4'd1;
  localparam ula_sel_t ULA_SUB   = 4'd2;
  localparam ula_sel_t ULA_SLL   = 4'd3;
  localparam ula_sel_t ULA_SLT   = 4'd4;
  localparam ula_sel_t ULA_SLTU  = 4'd5;
  localparam ula_sel_t ULA_SRL   = 4'd6;
  localparam ula_sel_t ULA_SRA   = 4'd7;
  localparam ula_sel_t ULA_XOR   = 4'd8;
  localparam ula_sel_t ULA_OR    = 4'd9;
  localparam ula_sel_t ULA_AND   = 4'd10;
  localparam ula_sel_t ULA_LUI   = 4'd11;
  localparam ula_sel_t ULA_AUIPC = 4'd12;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {OP1_ZERO, OP1_RS1, OP1_PC} op1_sel_e;
  typedef enum logic [1:0] {OP2_ZERO, OP2_RS2, OP2_IMM} op2_sel_e;

  typedef struct packed {
    ula_sel_t sel;
    op1_sel_e op1;
    op2_sel_e op2;
    logic     wb_en;
    logic     illegal;
  } dec_ctrl_t;

  // Shared OP / OP-IMM funct3 mapping; only OP may turn f7b5 on f3=000 into SUB.
  function automatic ula_sel_t alu_f3_sel(input logic [2:0] f3, input logic f7b5,
                                          input logic allow_sub);
    ula_sel_t s;
    case (f3)
      3'b000:  s = (allow_sub && f7b5) ? ULA_SUB : ULA_ADD;
      3'b001:  s = ULA_SLL;
      3'b010:  s = ULA_SLT;
      3'b011:  s = ULA_SLTU;
      3'b100:  s = ULA_XOR;
      3'b101:  s = f7b5 ? ULA_SRA : ULA_SRL;
      3'b110:  s = ULA_OR;
      default: s = ULA_AND;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ula_decode.sv
// Combinational RV32I decode into ULA select, operand-mux controls, writeback and illegal flags.
module ula_decode
  import ula_defs_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [4:0] rd,
  output dec_ctrl_t  ctrl_c
);

  logic writes_rd;

  always_comb begin
    ctrl_c    = '{sel: ULA_NONE, op1: OP1_ZERO, op2: OP2_ZERO, wb_en: 1'b0, illegal: 1'b1};
    writes_rd = 1'b1;
    case (opcode)
      OPC_OP:     ctrl_c = '{alu_f3_sel(funct3, funct7b5, 1'b1), OP1_RS1, OP2_RS2, 1'b0, 1'b0};
      OPC_OP_IMM: ctrl_c = '{alu_f3_sel(funct3, funct7b5, 1'b0), OP1_RS1, OP2_IMM, 1'b0, 1'b0};
      OPC_LUI:    ctrl_c = '{ULA_LUI, OP1_ZERO, OP2_IMM, 1'b0, 1'b0};
      OPC_AUIPC:  ctrl_c = '{ULA_AUIPC, OP1_PC, OP2_IMM, 1'b0, 1'b0};
      OPC_LOAD, OPC_JALR:
                  ctrl_c = '{ULA_ADD, OP1_RS1, OP2_IMM, 1'b0, 1'b0};
      OPC_STORE: begin
        ctrl_c    = '{ULA_ADD, OP1_RS1, OP2_IMM, 1'b0, 1'b0};
        writes_rd = 1'b0;
      end
      OPC_BRANCH: begin
        writes_rd = 1'b0;
        case (funct3[2:1])
          2'b00:   ctrl_c = '{ULA_SUB, OP1_RS1, OP2_RS2, 1'b0, 1'b0};
          2'b10:   ctrl_c = '{ULA_SLT, OP1_RS1, OP2_RS2, 1'b0, 1'b0};
          2'b11:   ctrl_c = '{ULA_SLTU, OP1_RS1, OP2_RS2, 1'b0, 1'b0};
          default: ;
        endcase
      end
      default: ;
    endcase
    ctrl_c.wb_en = !ctrl_c.illegal && writes_rd && (rd != 5'd0);
  end

endmodule

// File: rtl/ula_issue_stage.sv
// Issue register ahead of the ULA: decodes the instruction and holds it in a 2-entry
// skid buffer so a downstream stall never reaches decode combinationally.
module ula_issue_stage
  import ula_defs_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] data1_out,
  output logic [XLEN-1:0] data2_out,
  output logic [3:0]      select_ula,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    ula_sel_t        sel;
    logic [4:0]      rd;
    logic            wb_en;
    logic            illegal;
  } payload_t;

  dec_ctrl_t dec_c;
  payload_t  in_pl_c;
  payload_t  main_q, main_d, skid_q, skid_d;
  logic      main_valid_q, main_valid_d;
  logic      skid_valid_q, skid_valid_d;
  logic      rdy_q, rdy_d;
  logic      accept_c, consume_c;

  ula_decode u_decode (
    .opcode   (in_opcode),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .rd       (in_rd),
    .ctrl_c   (dec_c)
  );

  // Operand selection happens before the registers so the ULA sees flop outputs only.
  always_comb begin
    in_pl_c         = '0;
    in_pl_c.sel     = dec_c.sel;
    in_pl_c.rd      = in_rd;
    in_pl_c.wb_en   = dec_c.wb_en;
    in_pl_c.illegal = dec_c.illegal;
    case (dec_c.op1)
      OP1_RS1: in_pl_c.data1 = in_rs1_data;
      OP1_PC:  in_pl_c.data1 = in_pc;
      default: in_pl_c.data1 = '0;
    endcase
    case (dec_c.op2)
      OP2_RS2: in_pl_c.data2 = in_rs2_data;
      OP2_IMM: in_pl_c.data2 = in_imm;
      default: in_pl_c.data2 = '0;
    endcase
  end

  // rdy_q is low only in reset; with the skid enabled it also tracks a free skid slot.
  assign in_ready  = SKID_EN ? rdy_q : (rdy_q && (!main_valid_q || out_ready));
  assign accept_c  = in_valid && in_ready && !flush;
  assign consume_c = main_valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || consume_c) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept_c;
        if (accept_c) main_d = in_pl_c;
      end
    end else if (accept_c) begin
      skid_d       = in_pl_c;
      skid_valid_d = 1'b1;
    end
    rdy_d = SKID_EN ? !skid_valid_d : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      rdy_q        <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      rdy_q        <= rdy_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign data1_out   = main_q.data1;
  assign data2_out   = main_q.data2;
  assign select_ula  = main_q.sel;
  assign out_rd      = main_q.rd;
  assign out_wb_en   = main_q.wb_en;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_ula_issue_stage.sv
// Directed self-checking bench for ula_issue_stage: decode, skid ordering, flush and reset.
module tb_ula_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data1_out, data2_out;
  logic [3:0]  select_ula;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  ula_issue_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_funct3   (in_funct3),
    .in_funct7b5 (in_funct7b5),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .in_imm      (in_imm),
    .in_pc       (in_pc),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data1_out   (data1_out),
    .data2_out   (data2_out),
    .select_ula  (select_ula),
    .out_rd      (out_rd),
    .out_wb_en   (out_wb_en),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    in_opcode   = opc;
    in_funct3   = f3;
    in_funct7b5 = f7;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
    in_imm      = imm;
    in_pc       = pc;
    in_rd       = rd;
    in_valid    = 1'b1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] sel, input logic [31:0] d1,
                            input logic [31:0] d2, input logic wb, input logic ill);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".sel"}, 32'(select_ula), 32'(sel));
    check({tag, ".d1"}, data1_out, d1);
    check({tag, ".d2"}, data2_out, d2);
    check({tag, ".wb"}, 32'(out_wb_en), 32'(wb));
    check({tag, ".ill"}, 32'(out_illegal), 32'(ill));
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    issue(7'b0, 3'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    in_valid  = 1'b0;
    #22;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.ready", 32'(in_ready), 32'd0);
    check("rst.d1", data1_out, 32'd0);
    check("rst.sel", 32'(select_ula), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst.ready_hold", 32'(in_ready), 32'd0);
    step();
    check("rst.ready_up", 32'(in_ready), 32'd1);

    // Single-issue decode vectors with the consumer always ready
    issue(7'b0110011, 3'b000, 1'b0, 32'h55555555, 32'hAAAAAAAA, 32'h0, 32'h0, 5'd3);
    step(); in_valid = 1'b0;
    expect_out("add", 4'd1, 32'h55555555, 32'hAAAAAAAA, 1'b1, 1'b0);
    check("add.rd", 32'(out_rd), 32'd3);

    issue(7'b0010011, 3'b101, 1'b1, 32'h83800155, 32'h0, 32'd4, 32'h0, 5'd4);
    step(); in_valid = 1'b0;
    expect_out("srai", 4'd7, 32'h83800155, 32'd4, 1'b1, 1'b0);

    issue(7'b0010011, 3'b101, 1'b0, 32'h83800155, 32'h0, 32'd4, 32'h0, 5'd4);
    step(); in_valid = 1'b0;
    expect_out("srli", 4'd6, 32'h83800155, 32'd4, 1'b1, 1'b0);

    issue(7'b0010011, 3'b000, 1'b1, 32'h10, 32'h99, 32'h20, 32'h0, 5'd4);
    step(); in_valid = 1'b0;
    expect_out("addi_f7", 4'd1, 32'h10, 32'h20, 1'b1, 1'b0);

    issue(7'b0010111, 3'b000, 1'b0, 32'h77, 32'h0, 32'h40, 32'h40, 5'd5);
    step(); in_valid = 1'b0;
    expect_out("auipc", 4'd12, 32'h40, 32'h40, 1'b1, 1'b0);

    issue(7'b0110111, 3'b000, 1'b0, 32'hDEAD, 32'h0, 32'h12345000, 32'h80, 5'd6);
    step(); in_valid = 1'b0;
    expect_out("lui", 4'd11, 32'h0, 32'h12345000, 1'b1, 1'b0);

    issue(7'b0100011, 3'b010, 1'b0, 32'h1000, 32'h5, 32'h8, 32'h0, 5'd7);
    step(); in_valid = 1'b0;
    expect_out("store", 4'd1, 32'h1000, 32'h8, 1'b0, 1'b0);

    issue(7'b1100011, 3'b110, 1'b0, 32'h3, 32'h4, 32'h10, 32'h0, 5'd8);
    step(); in_valid = 1'b0;
    expect_out("bltu", 4'd5, 32'h3, 32'h4, 1'b0, 1'b0);

    issue(7'b1100011, 3'b010, 1'b0, 32'h3, 32'h4, 32'h10, 32'h0, 5'd8);
    step(); in_valid = 1'b0;
    expect_out("br_bad", 4'd0, 32'h0, 32'h0, 1'b0, 1'b1);

    issue(7'b0110011, 3'b000, 1'b1, 32'h9, 32'h2, 32'h0, 32'h0, 5'd0);
    step(); in_valid = 1'b0;
    expect_out("sub_x0", 4'd2, 32'h9, 32'h2, 1'b0, 1'b0);

    issue(7'b1111111, 3'b000, 1'b0, 32'h9, 32'h2, 32'h3, 32'h4, 5'd9);
    step(); in_valid = 1'b0;
    expect_out("illegal", 4'd0, 32'h0, 32'h0, 1'b0, 1'b1);

    step();
    check("drain.valid", 32'(out_valid), 32'd0);

    // Stall with A, B, C back to back: A in main, B in skid, C refused
    out_ready = 1'b0;
    issue(7'b0110011, 3'b000, 1'b0, 32'hA, 32'h0, 32'h0, 32'h0, 5'd1);
    step();
    check("stall.A", data1_out, 32'hA);
    check("stall.ready1", 32'(in_ready), 32'd1);
    issue(7'b0110011, 3'b000, 1'b0, 32'hB, 32'h0, 32'h0, 32'h0, 5'd1);
    step();
    check("stall.hold1", data1_out, 32'hA);
    check("stall.ready2", 32'(in_ready), 32'd0);
    issue(7'b0110011, 3'b000, 1'b0, 32'hC, 32'h0, 32'h0, 32'h0, 5'd1);
    step();
    check("stall.hold2", data1_out, 32'hA);
    check("stall.ready3", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    check("order.A", data1_out, 32'hA);
    step();
    check("order.B", data1_out, 32'hB);
    check("order.B_valid", 32'(out_valid), 32'd1);
    check("order.ready", 32'(in_ready), 32'd1);
    step(); in_valid = 1'b0;
    check("order.C", data1_out, 32'hC);
    check("order.C_valid", 32'(out_valid), 32'd1);
    step();
    check("order.empty", 32'(out_valid), 32'd0);

    // Flush with both entries full and a new instruction offered
    out_ready = 1'b0;
    issue(7'b0110011, 3'b000, 1'b0, 32'h11, 32'h0, 32'h0, 32'h0, 5'd1);
    step();
    issue(7'b0110011, 3'b000, 1'b0, 32'h22, 32'h0, 32'h0, 32'h0, 5'd1);
    step();
    issue(7'b0110011, 3'b000, 1'b0, 32'h33, 32'h0, 32'h0, 32'h0, 5'd1);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush.valid", 32'(out_valid), 32'd0);
    check("flush.ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    step();
    check("flush.skid_empty", 32'(out_valid), 32'd0);

    // Flush beats an accept in the same cycle
    issue(7'b0110011, 3'b000, 1'b0, 32'h44, 32'h0, 32'h0, 32'h0, 5'd1);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_prio.valid", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    issue(7'b0110011, 3'b000, 1'b0, 32'h55, 32'h0, 32'h0, 32'h0, 5'd1);
    step();
    issue(7'b0110011, 3'b000, 1'b0, 32'h66, 32'h0, 32'h0, 32'h0, 5'd1);
    step();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(out_valid), 32'd0);
    check("arst.ready", 32'(in_ready), 32'd0);
    check("arst.d1", data1_out, 32'd0);
    #1 rst_n = 1'b1;
    #1;
    check("arst.ready_hold", 32'(in_ready), 32'd0);
    step();
    check("arst.ready_up", 32'(in_ready), 32'd1);
    check("arst.still_empty", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_issue_stage.md
Name: ula_issue_stage

Overview:
- Execute-stage issue register that sits directly upstream of the ALU (ula) in the RV32I core.
- Accepts decoded instruction fields from the decode stage through a valid/ready handshake.
- Decodes opcode/funct3/funct7[5] into the 4-bit ULA select code and selects both ALU operands.
- Buffers the result in a 2-entry skid buffer so that downstream stalls never create a combinational ready path back to decode.

Parameters:
- XLEN, 32, datapath width of operands, pc and immediate.
- SKID_EN, 1, 1 = 2-entry skid buffer; 0 = single register with in_ready = !out_valid || out_ready.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all buffered entries (branch redirect).
- in_valid  in  1  decode has an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_opcode  in  7  instr[6:0].
- in_funct3  in  3  instr[14:12].
- in_funct7b5  in  1  instr[30].
- in_rs1_data  in  XLEN  register-file read 1.
- in_rs2_data  in  XLEN  register-file read 2.
- in_imm  in  XLEN  sign-extended immediate, already formatted by decode (I/S/B/U).
- in_pc  in  XLEN  instruction pc.
- in_rd  in  5  destination register.
- out_valid  out  1  ALU inputs are valid.
- out_ready  in  1  execute consumes this cycle.
- data1_out  out  XLEN  drives ula data1_in.
- data2_out  out  XLEN  drives ula data2_in.
- select_ula  out  4  drives ula select_ula.
- out_rd  out  5  destination register.
- out_wb_en  out  1  writes rd (0 for STORE, BRANCH and illegal opcodes, and whenever rd = 0).
- out_illegal  out  1  unsupported opcode/funct combination.

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0 and in_ready is 0; in_ready goes to 1 on the first clk after reset is released. All storage is invalidated. Reset asserted mid-transfer drops the entry.
- Accept: an entry is accepted when in_valid && in_ready. Consume: an entry is consumed when out_valid && out_ready.
- Latency: an accepted instruction appears on the outputs on the next rising edge. Throughput is 1 per cycle while out_ready = 1.
- Skid buffer (SKID_EN = 1):
  - in_ready is a register equal to !skid_valid.
  - If main holds an entry, out_ready = 0, and an accept occurs, the new entry goes to skid and in_ready drops next cycle.
  - When main is consumed and skid is valid, skid moves to main and in_ready rises.
  - Simultaneous accept and consume with an empty skid: the new entry loads main directly.
  - Ordering is strictly FIFO.
- flush: has priority over accept in the same cycle. Next cycle out_valid = 0 and skid is empty. in_ready is 1 in the cycle after a flush.
- Payload registers hold their value while out_valid && !out_ready; they must not change under a stall.
- Decode (registered with the payload), using the select codes ADD=1, SUB=2, SLL=3, SLT=4, SLTU=5, SRL=6, SRA=7, XOR=8, OR=9, AND=10, LUI=11, AUIPC=12:
  - OP (0110011): data1 = rs1, data2 = rs2.
    - f3 000: ADD, or SUB when f7b5 = 1.
    - f3 001: SLL. f3 010: SLT. f3 011: SLTU. f3 100: XOR.
    - f3 101: SRL, or SRA when f7b5 = 1.
    - f3 110: OR. f3 111: AND.
  - OP-IMM (0010011): same mapping with data2 = imm. SUB is never selected. f7b5 selects SRA only for f3 101.
  - LUI (0110111): LUI, data1 = 0, data2 = imm.
  - AUIPC (0010111): AUIPC, data1 = pc, data2 = imm.
  - LOAD (0000011) / STORE (0100011): ADD, data1 = rs1, data2 = imm.
  - JALR (1100111): ADD, data1 = rs1, data2 = imm.
  - BRANCH (1100011): data1 = rs1, data2 = rs2.
    - f3 000/001: SUB.
    - f3 100/101: SLT.
    - f3 110/111: SLTU.
    - f3 010/011: illegal.
  - Any other opcode: select_ula = 0, data1 = data2 = 0, out_illegal = 1, out_wb_en = 0. The entry still flows through the handshake normally.
- Widths: all operand paths are XLEN wide with no extension inside this block. Shift amount truncation is owned by ula.

Decomposition:
- Shared package/header ula_defs: ULA_* select codes (same values as used by ula) and OPC_* RV32I opcode constants.
- One combinational sub-module, ula_decode (opcode/f3/f7b5 → select, operand-mux controls, wb_en, illegal). Its outputs are captured by the skid registers in ula_issue_stage.

Test Plan:
- OP ADD with rs1=0x55555555, rs2=0xAAAAAAAA, out_ready=1 → next cycle out_valid=1, select_ula=1, data1_out=0x55555555, data2_out=0xAAAAAAAA, out_wb_en=1.
- OP-IMM f3=101 f7b5=1 with rs1=0x83800155, imm=4 → select_ula=7, data2_out=4. Same inputs with f7b5=0 → select_ula=6.
- AUIPC with pc=0x40, imm=0x40 → select_ula=12, data1_out=0x40, data2_out=0x40. LUI with imm=0x12345000 → select_ula=11, data1_out=0.
- Back-to-back issue of A,B,C with out_ready=0 for 3 cycles:
  - A is held in main, B in skid; in_ready=0 from the second cycle.
  - C is not accepted.
  - After release, A, B, C emerge in order on consecutive cycles with no loss or duplication.
- flush asserted with main and skid both full and in_valid=1 → next cycle out_valid=0, the flush-cycle input is dropped, and in_ready=1.
- Opcode 1111111 → out_illegal=1, select_ula=0, out_wb_en=0.
- rst_n pulled low mid-stall → out_valid=0 immediately (asynchronously); in_ready=1 on the first clk after release.
